mult_iter: RTL and testbench

MULT_ITER -- requirements
Module: mult_iter

---
 rtl/mult_iter.sv | 114 +++++++++++
 tb/tb_mult_iter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative signed/unsigned multiplier, STEP multiplier bits per cycle
module mult_iter #(
    parameter int N    = 16,
    parameter int M    = 16,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             is_signed,
    input  logic [N-1:0]     mult1,
    input  logic [M-1:0]     mult2,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [N+M-1:0]   res
);

    localparam int W  = N + M;
    localparam int C  = M / STEP;
    localparam int CW = $clog2(C + 1);

    // An uneven STEP would leave multiplier bits unconsumed, so refuse to build.
    if ((STEP < 1) || (M % STEP != 0)) begin : g_bad_step
        $error("mult_iter: STEP must divide M exactly");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    mcand;
    logic [M-1:0]    mplier;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic [N-1:0]    mag1;
    logic [M-1:0]    mag2;
    logic [W-1:0]    step_prod;
    logic [W-1:0]    acc_next;

    // Operand magnitudes; the most negative value negates to itself, which read
    // unsigned is exactly 2^(width-1).
    always_comb begin
        mag1 = mult1;
        mag2 = mult2;
        if (is_signed && mult1[N-1]) mag1 = ~mult1 + N'(1);
        if (is_signed && mult2[M-1]) mag2 = ~mult2 + M'(1);
    end

    // One partial product per cycle; mcand is pre-shifted so no variable shifter is needed.
    always_comb begin
        step_prod = mcand * W'(mplier[STEP-1:0]);
        acc_next  = acc + step_prod;
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            in_rdy  <= 1'b1;
            res_vld <= 1'b0;
            res     <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        mcand  <= W'(mag1);
                        mplier <= mag2;
                        neg    <= is_signed & (mult1[N-1] ^ mult2[M-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        in_rdy <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(C)) begin
                        res     <= neg ? (~acc + W'(1)) : acc;
                        res_vld <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << STEP;
                        mplier <= mplier >> STEP;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    res_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// tb/tb_mult_iter.sv - directed and golden-model checks for mult_iter
module tb_mult_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        is_signed;
    logic [15:0] mult1;
    logic [15:0] mult2;

    logic        in_vld_a, in_rdy_a, res_vld_a, res_rdy_a;
    logic [31:0] res_a;
    logic        in_vld_b, in_rdy_b, res_vld_b, res_rdy_b;
    logic [31:0] res_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_iter #(.N(16), .M(16), .STEP(1)) dut_a (
        .clk(clk), .rstn(rstn), .in_vld(in_vld_a), .in_rdy(in_rdy_a),
        .is_signed(is_signed), .mult1(mult1), .mult2(mult2),
        .res_vld(res_vld_a), .res_rdy(res_rdy_a), .res(res_a)
    );

    mult_iter #(.N(16), .M(16), .STEP(4)) dut_b (
        .clk(clk), .rstn(rstn), .in_vld(in_vld_b), .in_rdy(in_rdy_b),
        .is_signed(is_signed), .mult1(mult1), .mult2(mult2),
        .res_vld(res_vld_b), .res_rdy(res_rdy_b), .res(res_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on dut_a (sel=0) or dut_b (sel=1) and check latency and result.
    // With hold=1 the result is left pending in DONE for the caller to retire.
    task automatic run_op(input bit sel, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag,
                          input bit hold);
        int  wait_cnt;
        int  lat;
        bit  busy_rdy;
        wait_cnt = 0;
        while (!(sel ? in_rdy_b : in_rdy_a) && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_eq({tag, "_in_rdy_wait"}, 64'(wait_cnt < 100), 64'd1);
        is_signed = sgn;
        mult1     = a;
        mult2     = b;
        if (sel) in_vld_b = 1'b1; else in_vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vld_a  = 1'b0;
        in_vld_b  = 1'b0;
        is_signed = ~sgn;
        mult1     = ~a;
        mult2     = ~b;
        lat       = 0;
        busy_rdy  = 1'b0;
        while (!(sel ? res_vld_b : res_vld_a) && lat < 100) begin
            if (sel ? in_rdy_b : in_rdy_a) busy_rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_in_rdy_busy"}, 64'(busy_rdy), 64'd0);
        check_eq({tag, "_res"}, 64'(sel ? res_b : res_a), 64'(exp_res));
        if (!hold) begin
            if (sel) res_rdy_b = 1'b1; else res_rdy_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_rdy_a = 1'b0;
            res_rdy_b = 1'b0;
            check_eq({tag, "_vld_drop"}, 64'(sel ? res_vld_b : res_vld_a), 64'd0);
            check_eq({tag, "_rdy_back"}, 64'(sel ? in_rdy_b : in_rdy_a), 64'd1);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit          rs;
        longint      pa, pb;
        logic [31:0] gold;

        rstn = 1'b0;
        in_vld_a = 1'b0; in_vld_b = 1'b0;
        res_rdy_a = 1'b0; res_rdy_b = 1'b0;
        is_signed = 1'b0; mult1 = '0; mult2 = '0;
        @(posedge clk);
        @(negedge clk);
        in_vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vld_a = 1'b0;
        check_eq("rst_in_rdy", 64'(in_rdy_a), 64'd1);
        check_eq("rst_res_vld", 64'(res_vld_a), 64'd0);
        check_eq("rst_res", 64'(res_a), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_accept_blocked", 64'(in_rdy_a), 64'd1);

        run_op(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, "u_ffff", 0);
        run_op(0, 1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 17, "s_m3x5", 0);
        run_op(0, 1, 16'h8000, 16'h8000, 32'h40000000, 17, "s_minxmin", 0);
        run_op(0, 1, 16'h8000, 16'h7FFF, 32'hC0008000, 17, "s_minxmax", 0);
        run_op(0, 1, 16'h0000, 16'h8000, 32'h00000000, 17, "s_zero", 0);
        run_op(0, 0, 16'h8000, 16'h8000, 32'h40000000, 17, "u_8000sq", 0);
        run_op(0, 1, 16'h7FFF, 16'hFFFF, 32'hFFFF8001, 17, "s_maxxm1", 0);

        // Back-pressure: result held in DONE while new operands are offered and ignored.
        run_op(0, 0, 16'h0123, 16'h0456, 32'h0004EDC2, 17, "bp", 1);
        for (int i = 0; i < 5; i++) begin
            in_vld_a = i[0];
            mult1 = 16'h1111 * 16'(i + 1);
            mult2 = 16'h0F0F;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_res_hold", 64'(res_a), 64'h0004EDC2);
            check_eq("bp_vld_hold", 64'(res_vld_a), 64'd1);
        end
        in_vld_a  = 1'b0;
        res_rdy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_rdy_a = 1'b0;
        check_eq("bp_in_rdy", 64'(in_rdy_a), 64'd1);
        check_eq("bp_vld_once", 64'(res_vld_a), 64'd0);

        // Reset in the middle of BUSY discards the pending product.
        is_signed = 1'b0; mult1 = 16'h1234; mult2 = 16'h5678;
        in_vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vld_a = 1'b0;
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_eq("abort_in_rdy", 64'(in_rdy_a), 64'd1);
        check_eq("abort_res_vld", 64'(res_vld_a), 64'd0);
        check_eq("abort_res", 64'(res_a), 64'd0);
        repeat (20) begin
            @(negedge clk);
            if (res_vld_a) check_eq("abort_no_result", 64'(res_vld_a), 64'd0);
        end
        run_op(0, 0, 16'd3, 16'd7, 32'd21, 17, "after_abort", 0);

        // Four bits per cycle.
        run_op(1, 1, 16'h1234, 16'hFF00, 32'hFFEDCC00, 5, "s4_ff00", 0);
        run_op(1, 1, 16'h8000, 16'h8000, 32'h40000000, 5, "s4_minxmin", 0);
        run_op(1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "u4_ffff", 0);

        // Back-to-back mixed-mode operations against a 64-bit golden product.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            pa = rs ? longint'($signed(ra)) : longint'(ra);
            pb = rs ? longint'($signed(rb)) : longint'(rb);
            gold = 32'(pa * pb);
            run_op(i[0], rs, ra, rb, gold, i[0] ? 5 : 17, "rand", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
